// File: rtl/prod_accum_pkg.sv
// -----------------------------------------------------------------------------
// prod_accum_pkg
//   Shared definitions for the product accumulator that sits behind the 32x32
//   array multiplier. It holds the default widths, the FSM state encodings and
//   the small decode helpers that the accumulator uses.
//
//   Contents:
//     PW_DEF  : default product width (multiplier output c)
//     GW_DEF  : default guard bits above the product width
//     CW_DEF  : default width of the term-count field
//     ST_*    : 2-bit FSM state encodings (legacy-compatible constants)
//     st_busy / st_in_ready / st_out_valid : output decodes from the state
// -----------------------------------------------------------------------------
package prod_accum_pkg;

  localparam int PW_DEF = 64;
  localparam int GW_DEF = 8;
  localparam int CW_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Handshake outputs depend on the state register alone, so neither
  // in_valid nor out_ready has a combinational path to an output.
  function automatic logic st_in_ready(input logic [1:0] st);
    return (st == ST_ACC);
  endfunction

  function automatic logic st_out_valid(input logic [1:0] st);
    return (st == ST_DONE);
  endfunction

  function automatic logic st_busy(input logic [1:0] st);
    return (st == ST_ACC) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/prod_accum_add.sv
// -----------------------------------------------------------------------------
// acc_add
//   Combinational width-parameterised unsigned adder used for the running sum.
//   The carry out of the top bit is returned separately so the caller can
//   record a wrap of the accumulator.
//
//   Ports:
//     a    in  W  accumulator operand
//     b    in  W  zero-extended product operand
//     sum  out W  (a + b) mod 2^W
//     cout out 1  carry out of bit W-1
// -----------------------------------------------------------------------------
module acc_add #(
  parameter int W = 72
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/prod_accum.sv
// -----------------------------------------------------------------------------
// prod_accum
//   Sequential accumulator downstream of the 32x32 array multiplier. After a
//   start it sums len unsigned products, received over a valid/ready stream,
//   into a guard-extended register and then presents the total over a second
//   valid/ready handshake. Together with the multiplier this is the
//   multiply-accumulate (dot-product) path.
//
//   Parameters:
//     PW  product width (matches the multiplier output)
//     GW  guard bits; the accumulator is PW+GW bits wide
//     CW  width of the term-count field
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      synchronous active-low reset
//     start      in   1      begin an accumulation (sampled in IDLE only)
//     len        in   CW     number of products to sum (sampled with start)
//     abort      in   1      synchronous cancel from any state
//     in_valid   in   1      product beat valid
//     in_ready   out  1      product beat accepted when in_valid && in_ready
//     in_prod    in   PW     unsigned product
//     out_valid  out  1      result available
//     out_ready  in   1      result consumed when out_valid && out_ready
//     out_sum    out  PW+GW  accumulated sum modulo 2^(PW+GW)
//     out_ovf    out  1      sticky carry-out seen during this accumulation
//     busy       out  1      high in ACC and DONE
// -----------------------------------------------------------------------------
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int GW = GW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW+GW-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int AW = PW + GW;

  logic [1:0]    state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] len_q;
  logic          ovf;

  logic [AW-1:0] prod_ext;
  logic [AW-1:0] acc_nxt;
  logic          acc_cout;
  logic [CW-1:0] cnt_nxt;
  logic          beat;

  // Zero-extend the product into the accumulator width. Written as a slice
  // assignment so GW=0 needs no zero-width replication.
  always_comb begin
    prod_ext          = '0;
    prod_ext[PW-1:0]  = in_prod;
  end

  acc_add #(
    .W (AW)
  ) u_add (
    .a    (acc),
    .b    (prod_ext),
    .sum  (acc_nxt),
    .cout (acc_cout)
  );

  assign cnt_nxt = cnt + 1'b1;
  assign beat    = (state == ST_ACC) && in_valid;

  // ---- state / accumulator register stage ----
  // Priority is reset, then abort, then start and the two handshakes. An
  // abort that coincides with an accepted beat discards that beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            // A zero-length request completes immediately with a zero sum.
            state <= (len != '0) ? ST_ACC : ST_DONE;
          end
        end
        ST_ACC: begin
          if (beat) begin
            acc <= acc_nxt;
            ovf <= ovf | acc_cout;
            cnt <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Sum and overflow stay frozen until the result is taken; start is
          // deliberately not looked at here.
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---- output decode (state register only) ----
  assign in_ready  = st_in_ready(state);
  assign out_valid = st_out_valid(state);
  assign busy      = st_busy(state);
  assign out_sum   = acc;
  assign out_ovf   = ovf;

endmodule
